// File: rtl/cpu6_bus_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu6_bus_pkg : shared constants and FSM state type for the CPU6 bus unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu6_bus_pkg;

  localparam int PAGE_BITS  = 11;
  localparam int FRAME_BITS = 8;
  localparam int CTX_BITS   = 3;
  localparam int PHYS_WIDTH = FRAME_BITS + PAGE_BITS;
  localparam int IDX_BITS   = 16 - PAGE_BITS;
  localparam int MAP_ABITS  = CTX_BITS + IDX_BITS;

  localparam logic [7:0] FAULT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XLATE  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu6_bus_unit_if.sv
// ---------------------------------------------------------------------------
// cpu6_bus_unit_if : CPU-side, map-programming and fabric-side bus signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu6_bus_unit_if;
  import cpu6_bus_pkg::*;

  logic [15:0]           cpu_addr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [7:0]            cpu_rdata;
  logic                  cpu_wait;
  logic                  cpu_fault;
  logic                  fault_clr;
  logic                  ctx_we;
  logic                  pt_we;
  logic [IDX_BITS-1:0]   pt_index;
  logic [7:0]            pt_data;
  logic [PHYS_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_we;
  logic                  mem_req;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, fault_clr,
    input  ctx_we, pt_we, pt_index, pt_data, mem_ack, mem_rdata,
    output cpu_rdata, cpu_wait, cpu_fault,
    output mem_addr, mem_wdata, mem_we, mem_req
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, fault_clr,
    output ctx_we, pt_we, pt_index, pt_data, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_wait, cpu_fault,
    input  mem_addr, mem_wdata, mem_we, mem_req
  );

endinterface

`default_nettype wire

// File: rtl/cpu6_bus_unit_page_map.sv
// ---------------------------------------------------------------------------
// cpu6_page_map : 256x8 single-port map RAM, sync read, deferred writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu6_page_map
  import cpu6_bus_pkg::*;
(
  input  wire logic                 clock,
  input  wire logic                 reset_,
  input  wire logic                 i_rd_en,
  input  wire logic [MAP_ABITS-1:0] i_rd_addr,
  output logic      [7:0]           o_rd_data,
  input  wire logic                 i_wr_en,
  input  wire logic [MAP_ABITS-1:0] i_wr_addr,
  input  wire logic [7:0]           i_wr_data
);

  logic [7:0]           r_mem [0:(1<<MAP_ABITS)-1];
  logic [7:0]           r_q;
  logic                 r_pend_v;
  logic [MAP_ABITS-1:0] r_pend_addr;
  logic [7:0]           r_pend_data;

  logic                 w_do_wr;
  logic [MAP_ABITS-1:0] w_wa;
  logic [7:0]           w_wd;
  logic                 w_pend_v_nx;
  logic [MAP_ABITS-1:0] w_pend_addr_nx;
  logic [7:0]           w_pend_data_nx;

  // The lookup read owns the port; a colliding write waits in a one-entry
  // buffer and drains on the next read-free cycle.
  always_comb begin
    w_do_wr        = 1'b0;
    w_wa           = r_pend_addr;
    w_wd           = r_pend_data;
    w_pend_v_nx    = r_pend_v;
    w_pend_addr_nx = r_pend_addr;
    w_pend_data_nx = r_pend_data;
    if (i_rd_en) begin
      if (i_wr_en && (!r_pend_v || (i_wr_addr == r_pend_addr))) begin
        w_pend_v_nx    = 1'b1;
        w_pend_addr_nx = i_wr_addr;
        w_pend_data_nx = i_wr_data;
      end
    end else if (r_pend_v) begin
      w_do_wr        = 1'b1;
      w_pend_v_nx    = i_wr_en;
      w_pend_addr_nx = i_wr_addr;
      w_pend_data_nx = i_wr_data;
    end else if (i_wr_en) begin
      w_do_wr = 1'b1;
      w_wa    = i_wr_addr;
      w_wd    = i_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      r_pend_v    <= w_pend_v_nx;
      r_pend_addr <= w_pend_addr_nx;
      r_pend_data <= w_pend_data_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end else if (w_do_wr) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  assign o_rd_data = r_q;

endmodule

`default_nettype wire

// File: rtl/cpu6_bus_unit.sv
// ---------------------------------------------------------------------------
// cpu6_bus_unit : paged address translation and req/ack bus sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu6_bus_unit
  import cpu6_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  wire logic       clock,
  input  wire logic       reset_,
  cpu6_bus_unit_if.master bus
);

  localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [CTX_BITS-1:0]   r_ctx;
  logic [PAGE_BITS-1:0]  r_offset;
  logic                  r_wflag;
  logic [7:0]            r_timer;
  logic [PHYS_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_mem_req;
  logic [7:0]            r_rdata;
  logic                  r_fault;

  logic                  w_strobe;
  logic                  w_start;
  logic                  w_timeout;
  logic [FRAME_BITS-1:0] w_map_q;

  assign w_strobe  = bus.cpu_rd | bus.cpu_wr;
  assign w_start   = (r_state == ST_IDLE) && w_strobe;
  assign w_timeout = (r_state == ST_ACCESS) && !bus.mem_ack && (r_timer == c_TIMER_LAST);

  cpu6_page_map u_page_map (
    .clock     (clock),
    .reset_    (reset_),
    .i_rd_en   (w_start),
    .i_rd_addr ({r_ctx, bus.cpu_addr[15:PAGE_BITS]}),
    .o_rd_data (w_map_q),
    .i_wr_en   (bus.pt_we),
    .i_wr_addr ({r_ctx, bus.pt_index}),
    .i_wr_data (bus.pt_data)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_ctx       <= '0;
      r_offset    <= '0;
      r_wflag     <= 1'b0;
      r_timer     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (bus.ctx_we) begin
        r_ctx <= bus.pt_data[CTX_BITS-1:0];
      end
      // Clear beats a same-cycle timeout set.
      if (bus.fault_clr) begin
        r_fault <= 1'b0;
      end else if (w_timeout) begin
        r_fault <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_offset <= bus.cpu_addr[PAGE_BITS-1:0];
            r_wflag  <= bus.cpu_wr;
            if (bus.cpu_wr) begin
              r_mem_wdata <= bus.cpu_wdata;
            end
            r_state <= ST_XLATE;
          end
        end
        ST_XLATE: begin
          r_mem_addr <= {w_map_q, r_offset};
          r_mem_req  <= 1'b1;
          r_mem_we   <= r_wflag;
          r_timer    <= '0;
          r_state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= r_wflag ? 8'h00 : bus.mem_rdata;
            r_state   <= ST_DONE;
          end else if (r_timer == c_TIMER_LAST) begin
            r_mem_req <= 1'b0;
            r_rdata   <= FAULT_DATA;
            r_state   <= ST_DONE;
          end else if (r_timer != 8'hFF) begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_wait  = w_start || (r_state == ST_XLATE) || (r_state == ST_ACCESS);
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_fault = r_fault;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_req   = r_mem_req;

endmodule

`default_nettype wire
